// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of the
//   dmem_arbiter into one interface.
//
//   Requester N (N = 0, 1):
//     reqN    request, held until ackN
//     weN     1 = write, 0 = read
//     addrN   access address
//     wdataN  write data
//     ackN    one-cycle completion pulse
//     rdataN  registered read result
//   Data memory:
//     mem_address, mem_write_data, mem_write, mem_read  (to memory)
//     mem_read_data  (from memory, valid one cycle after mem_read)
//
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters and memory)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output mem_address, mem_write_data, mem_write, mem_read,
    input  mem_read_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_address, mem_write_data, mem_write, mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of a single data memory. One access is in
//   flight at a time through a three-state FSM:
//     IDLE  : pick a winner among req0/req1, latch its command
//     ISSUE : drive mem_write or mem_read for one cycle
//     RESP  : pulse ack to the owner; a read captures mem_read_data into
//             the owner's rdata register at the end of this cycle
//   Latency: request sampled at edge T, strobe in cycle T+1, ack in T+2.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - dmem_arbiter_if.slave (requester ports + memory port)
//
// Configuration:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a tie,
//                                        no last-grant register
//                           undefined -> round-robin on ties
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic                  owner_q,     owner_d;
  logic                  cmd_we_q,    cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  ack0_q,      ack0_d;
  logic                  ack1_q,      ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q,    rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,    rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                  last_grant_q, last_grant_d;
`endif

  logic                  any_req;
  logic                  winner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign any_req = bus.req0 | bus.req1;

  // Winner selection: a lone requester always wins; a tie goes to the port
  // not granted last (round-robin) or to port 0 (fixed priority).
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    sel_we    = winner ? bus.we1    : bus.we0;
    sel_addr  = winner ? bus.addr1  : bus.addr0;
    sel_wdata = winner ? bus.wdata1 : bus.wdata0;
  end

  // Next-state and next-output logic. Strobes and acks default low so they
  // are asserted only in the one cycle that calls for them; command,
  // owner and rdata registers hold unless explicitly loaded.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ISSUE;
          owner_d     = winner;
          cmd_we_d    = sel_we;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          // Strobes are registered, so they are set up here to appear in
          // ISSUE; they are mutually exclusive by construction.
          mem_write_d = sel_we;
          mem_read_d  = ~sel_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_grant_d = winner;
`endif
        end
      end

      ISSUE: begin
        state_d = RESP;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
      end

      RESP: begin
        state_d = IDLE;
        // Memory read data is valid during RESP (one cycle after the read
        // strobe) and is captured at the RESP->IDLE edge.
        if (!cmd_we_q) begin
          if (owner_q) rdata1_d = bus.mem_read_data;
          else         rdata0_d = bus.mem_read_data;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the registered outputs; reset clears everything
  // immediately so an in-flight access is abandoned without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      // Port 0 wins the first tie after reset.
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.mem_address    = cmd_addr_q;
  assign bus.mem_write_data = cmd_wdata_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;

endmodule
